// File: rtl/mbtrain_rx_cal_rx.sv
`default_nettype none
// ============================================================================
//  Module   : mbtrain_rx_cal_rx
//  Purpose  : Responder side of the MBTRAIN RX-clock calibration substep.
//             Answers the initiator's start request (0001) with a start
//             response (0010) once the local receiver calibration engine
//             has finished or its cycle cap is reached. It then answers the
//             end request (0011) with an end response (0100).
//  Ports    : clk, rst                  - clock, synchronous active-high reset
//             i_en                      - substep enable (level)
//             i_decoded_sideband_message/i_sideband_valid - received message
//             i_busy_negedge_detected   - sideband TX finished a transfer
//             i_valid_rx                - initiator valid on the shared TX mux
//             i_cal_done                - calibration engine finished
//             o_sideband_message/o_valid_tx - message pending on the TX mux
//             o_cal_en                  - calibration engine enable
//             o_test_ack / o_timeout    - substep completed / timed out
//  Options  : RX_CAL_TIMEOUT_EN - enables the substep timeout counter
//  Revision : 1.0 - initial release
// ============================================================================
module mbtrain_rx_cal_rx #(
    parameter int CAL_MAX_CYCLES = 64,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    input  logic [3:0] i_decoded_sideband_message,
    input  logic       i_sideband_valid,
    input  logic       i_busy_negedge_detected,
    input  logic       i_valid_rx,
    input  logic       i_cal_done,
    output logic [3:0] o_sideband_message,
    output logic       o_valid_tx,
    output logic       o_cal_en,
    output logic       o_test_ack,
    output logic       o_timeout
);

    localparam logic [3:0] c_START_REQ  = 4'b0001;
    localparam logic [3:0] c_START_RESP = 4'b0010;
    localparam logic [3:0] c_END_REQ    = 4'b0011;
    localparam logic [3:0] c_END_RESP   = 4'b0100;

    localparam int                 c_CAL_W    = (CAL_MAX_CYCLES > 1) ? $clog2(CAL_MAX_CYCLES) : 1;
    localparam logic [c_CAL_W-1:0] c_CAL_LAST = c_CAL_W'(CAL_MAX_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE            = 3'd0,
        S_WAIT_START_REQ  = 3'd1,
        S_CAL             = 3'd2,
        S_SEND_START_RESP = 3'd3,
        S_WAIT_END_REQ    = 3'd4,
        S_SEND_END_RESP   = 3'd5,
        S_DONE            = 3'd6,
        S_TIMEOUT         = 3'd7
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [3:0]         r_msg, w_msg_nxt;
    logic               r_valid, w_valid_nxt;
    logic               r_cal_en, w_cal_en_nxt;
    logic               r_ack, w_ack_nxt;
    logic               r_pend, w_pend_nxt;
    logic [c_CAL_W-1:0] r_cal_cnt, w_cal_cnt_nxt;

    logic w_clear;
    logic w_start_req;
    logic w_end_req;

`ifdef RX_CAL_TIMEOUT_EN
    localparam int                c_TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);

    logic [c_TO_W-1:0] r_to_cnt, w_to_cnt_nxt;
    logic              r_timeout, w_timeout_nxt;
`else
    // Timeout length is meaningless in this build; kept as a parameter so
    // instantiations are identical in both builds.
    logic w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

    // A pending TX message is released only when the sideband TX finished
    // our transfer, i.e. the initiator did not own the mux at that negedge.
    assign w_clear     = i_busy_negedge_detected && !i_valid_rx;
    assign w_start_req = i_sideband_valid && (i_decoded_sideband_message == c_START_REQ);
    assign w_end_req   = i_sideband_valid && (i_decoded_sideband_message == c_END_REQ);

    always_comb begin
        w_state_nxt   = r_state;
        w_msg_nxt     = r_msg;
        w_valid_nxt   = r_valid;
        w_cal_en_nxt  = r_cal_en;
        w_ack_nxt     = r_ack;
        w_pend_nxt    = r_pend;
        w_cal_cnt_nxt = r_cal_cnt;
`ifdef RX_CAL_TIMEOUT_EN
        w_to_cnt_nxt  = r_to_cnt;
        w_timeout_nxt = r_timeout;
`endif

        case (r_state)
            S_IDLE: begin
                if (i_en) begin
                    w_state_nxt = S_WAIT_START_REQ;
                end
            end
            S_WAIT_START_REQ: begin
                if (w_start_req) begin
                    w_state_nxt   = S_CAL;
                    w_cal_en_nxt  = 1'b1;
                    w_cal_cnt_nxt = '0;
                end
            end
            S_CAL: begin
                // An end request can overtake our start response; remember it.
                if (w_end_req) begin
                    w_pend_nxt = 1'b1;
                end
                if (i_cal_done || (r_cal_cnt == c_CAL_LAST)) begin
                    w_state_nxt = S_SEND_START_RESP;
                    w_msg_nxt   = c_START_RESP;
                    w_valid_nxt = 1'b1;
                end else if (r_cal_cnt != '1) begin
                    w_cal_cnt_nxt = r_cal_cnt + 1'b1;
                end
            end
            S_SEND_START_RESP: begin
                if (w_end_req) begin
                    w_pend_nxt = 1'b1;
                end
                if (w_clear) begin
                    w_state_nxt = S_WAIT_END_REQ;
                    w_valid_nxt = 1'b0;
                end
            end
            S_WAIT_END_REQ: begin
                if (r_pend || w_end_req) begin
                    w_state_nxt  = S_SEND_END_RESP;
                    w_cal_en_nxt = 1'b0;
                    w_msg_nxt    = c_END_RESP;
                    w_valid_nxt  = 1'b1;
                    w_pend_nxt   = 1'b0;
                end
            end
            S_SEND_END_RESP: begin
                if (w_clear) begin
                    w_state_nxt = S_DONE;
                    w_ack_nxt   = 1'b1;
                    w_msg_nxt   = 4'b0000;
                    w_valid_nxt = 1'b0;
                end
            end
            S_DONE: begin
                w_ack_nxt = 1'b1;
            end
            S_TIMEOUT: begin
                // Held until the enable drops (handled by the abort path).
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

`ifdef RX_CAL_TIMEOUT_EN
        // Timeout counts the whole active substep and overrides its progress.
        if ((r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_TIMEOUT)) begin
            if (r_to_cnt == c_TO_LAST) begin
                w_state_nxt   = S_TIMEOUT;
                w_timeout_nxt = 1'b1;
                w_cal_en_nxt  = 1'b0;
                w_valid_nxt   = 1'b0;
                w_msg_nxt     = 4'b0000;
                w_pend_nxt    = 1'b0;
            end else if (r_to_cnt != '1) begin
                w_to_cnt_nxt = r_to_cnt + 1'b1;
            end
        end
`endif

        // Dropping the enable abandons the substep from any state.
        if ((r_state != S_IDLE) && !i_en) begin
            w_state_nxt   = S_IDLE;
            w_msg_nxt     = 4'b0000;
            w_valid_nxt   = 1'b0;
            w_cal_en_nxt  = 1'b0;
            w_ack_nxt     = 1'b0;
            w_pend_nxt    = 1'b0;
            w_cal_cnt_nxt = '0;
`ifdef RX_CAL_TIMEOUT_EN
            w_to_cnt_nxt  = '0;
            w_timeout_nxt = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_msg     <= 4'b0000;
            r_valid   <= 1'b0;
            r_cal_en  <= 1'b0;
            r_ack     <= 1'b0;
            r_pend    <= 1'b0;
            r_cal_cnt <= '0;
`ifdef RX_CAL_TIMEOUT_EN
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_msg     <= w_msg_nxt;
            r_valid   <= w_valid_nxt;
            r_cal_en  <= w_cal_en_nxt;
            r_ack     <= w_ack_nxt;
            r_pend    <= w_pend_nxt;
            r_cal_cnt <= w_cal_cnt_nxt;
`ifdef RX_CAL_TIMEOUT_EN
            r_to_cnt  <= w_to_cnt_nxt;
            r_timeout <= w_timeout_nxt;
`endif
        end
    end

    assign o_sideband_message = r_msg;
    assign o_valid_tx         = r_valid;
    assign o_cal_en           = r_cal_en;
    assign o_test_ack         = r_ack;
`ifdef RX_CAL_TIMEOUT_EN
    assign o_timeout          = r_timeout;
`else
    assign o_timeout          = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mbtrain_rx_cal_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mbtrain_rx_cal_rx
//  Purpose  : Directed self-checking bench for mbtrain_rx_cal_rx. Expected
//             response codes are queued when requests are driven; a monitor
//             captures each rising o_valid_tx with its edge number, and the
//             main sequence pops and compares both.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mbtrain_rx_cal_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_en;
    logic [3:0] i_decoded_sideband_message;
    logic       i_sideband_valid;
    logic       i_busy_negedge_detected;
    logic       i_valid_rx;
    logic       i_cal_done;
    logic [3:0] o_sideband_message;
    logic       o_valid_tx;
    logic       o_cal_en;
    logic       o_test_ack;
    logic       o_timeout;

    mbtrain_rx_cal_rx #(
        .CAL_MAX_CYCLES (64),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk                        (clk),
        .rst                        (rst),
        .i_en                       (i_en),
        .i_decoded_sideband_message (i_decoded_sideband_message),
        .i_sideband_valid           (i_sideband_valid),
        .i_busy_negedge_detected    (i_busy_negedge_detected),
        .i_valid_rx                 (i_valid_rx),
        .i_cal_done                 (i_cal_done),
        .o_sideband_message         (o_sideband_message),
        .o_valid_tx                 (o_valid_tx),
        .o_cal_en                   (o_cal_en),
        .o_test_ack                 (o_test_ack),
        .o_timeout                  (o_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0] exp_q[$];
    logic [3:0] obs_msg_q[$];
    int         obs_cyc_q[$];
    logic       r_prev_valid = 1'b0;
    logic [3:0] r_prev_msg = 4'b0000;
    int         n_unstable = 0;

    // Capture each new TX message and watch message stability while valid.
    always @(negedge clk) begin
        if (o_valid_tx === 1'b1 && r_prev_valid !== 1'b1) begin
            obs_msg_q.push_back(o_sideband_message);
            obs_cyc_q.push_back(cyc);
        end
        if (o_valid_tx === 1'b1 && r_prev_valid === 1'b1 && o_sideband_message !== r_prev_msg)
            n_unstable <= n_unstable + 1;
        r_prev_valid <= o_valid_tx;
        r_prev_msg   <= o_sideband_message;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_msg(input logic [3:0] code);
        i_decoded_sideband_message = code;
        i_sideband_valid           = 1'b1;
        tick(1);
        i_sideband_valid           = 1'b0;
        i_decoded_sideband_message = 4'b0000;
    endtask

    task automatic busy_neg(input logic rx);
        i_busy_negedge_detected = 1'b1;
        i_valid_rx              = rx;
        tick(1);
        i_busy_negedge_detected = 1'b0;
        i_valid_rx              = 1'b0;
    endtask

    // Pop the next observed response; exp_cyc < 0 skips the timing check.
    task automatic sb_pop(input string tag, input int exp_cyc);
        int         n = 0;
        logic [3:0] e;
        while (obs_msg_q.size() == 0 && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({tag, "_seen"}, (obs_msg_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
        if (obs_msg_q.size() != 0) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 4'hx;
            chk({tag, "_msg"}, obs_msg_q.pop_front(), e);
            if (exp_cyc >= 0)
                chk({tag, "_cyc"}, obs_cyc_q.pop_front(), exp_cyc);
            else
                void'(obs_cyc_q.pop_front());
        end
    endtask

    function automatic logic [7:0] outs();
        return {o_sideband_message, o_valid_tx, o_cal_en, o_test_ack, o_timeout};
    endfunction

    int c0;
    int e_edge;

    initial begin
        rst = 1'b1;
        i_en = 1'b0;
        i_decoded_sideband_message = 4'b0000;
        i_sideband_valid = 1'b0;
        i_busy_negedge_detected = 1'b0;
        i_valid_rx = 1'b0;
        i_cal_done = 1'b0;
        tick(3);
        rst = 1'b0;
        chk("reset_outs", outs(), 8'h00);

        // Nominal handshake
        i_en = 1'b1;
        tick(1);
        chk("idle_exit_outs", outs(), 8'h00);
        exp_q.push_back(4'b0010);
        send_msg(4'b0001);
        c0 = cyc;
        chk("nom_cal_en_on", o_cal_en, 1'b1);
        tick(4);
        chk("nom_cal_window", {o_cal_en, o_valid_tx}, 2'b10);
        i_cal_done = 1'b1;
        tick(1);
        i_cal_done = 1'b0;
        sb_pop("nom_start_resp", c0 + 5);
        busy_neg(1'b0);
        chk("nom_start_clear", {o_valid_tx, o_cal_en}, 2'b01);
        exp_q.push_back(4'b0100);
        send_msg(4'b0011);
        chk("nom_end_cal_off", {o_cal_en, o_valid_tx}, 2'b01);
        sb_pop("nom_end_resp", -1);
        busy_neg(1'b0);
        chk("nom_done", outs(), 8'h02);
        tick(2);
        chk("nom_done_hold", o_test_ack, 1'b1);
        i_en = 1'b0;
        tick(1);
        chk("nom_ack_drop", outs(), 8'h00);

        // Calibration cap: no cal_done, response exactly 64 edges after entry
        i_en = 1'b1;
        tick(1);
        exp_q.push_back(4'b0010);
        send_msg(4'b0001);
        c0 = cyc;
        sb_pop("cap_start_resp", c0 + 64);
        chk("cap_cal_en", o_cal_en, 1'b1);
        i_en = 1'b0;
        tick(1);
        chk("cap_abort", outs(), 8'h00);

        // Early end request during CAL, then mux contention on the start response
        i_en = 1'b1;
        tick(1);
        exp_q.push_back(4'b0010);
        send_msg(4'b0001);
        tick(2);
        exp_q.push_back(4'b0100);
        send_msg(4'b0011);
        tick(2);
        i_cal_done = 1'b1;
        tick(1);
        i_cal_done = 1'b0;
        sb_pop("early_start_resp", -1);
        busy_neg(1'b1);
        chk("mux_hold", o_valid_tx, 1'b1);
        tick(3);
        chk("mux_hold_later", {o_valid_tx, o_sideband_message}, 5'b1_0010);
        busy_neg(1'b0);
        e_edge = cyc;
        chk("mux_clear", o_valid_tx, 1'b0);
        sb_pop("early_end_resp", e_edge + 1);
        busy_neg(1'b0);
        chk("early_done", outs(), 8'h02);
        i_en = 1'b0;
        tick(1);

        // Abort while in CAL
        i_en = 1'b1;
        tick(1);
        send_msg(4'b0001);
        tick(2);
        chk("abort_pre", o_cal_en, 1'b1);
        i_en = 1'b0;
        tick(1);
        chk("abort_cal", outs(), 8'h00);

        // Minimum latency, then reset while in SEND_END_RESP
        i_en = 1'b1;
        tick(1);
        i_cal_done = 1'b1;
        exp_q.push_back(4'b0010);
        send_msg(4'b0001);
        c0 = cyc;
        sb_pop("minlat_start_resp", c0 + 1);
        i_cal_done = 1'b0;
        busy_neg(1'b0);
        exp_q.push_back(4'b0100);
        send_msg(4'b0011);
        sb_pop("rst_end_resp", -1);
        rst = 1'b1;
        tick(1);
        chk("rst_mid", outs(), 8'h00);
        rst = 1'b0;
        i_en = 1'b0;
        tick(1);

        // Timeout behaviour
        i_en = 1'b1;
        tick(1);
`ifdef RX_CAL_TIMEOUT_EN
        tick(99);
        chk("to_before", o_timeout, 1'b0);
        tick(1);
        chk("to_fire", {o_timeout, o_cal_en, o_valid_tx}, 3'b100);
        tick(5);
        chk("to_hold", o_timeout, 1'b1);
        i_en = 1'b0;
        tick(1);
        chk("to_clear", outs(), 8'h00);
`else
        tick(150);
        chk("no_timeout", o_timeout, 1'b0);
        i_en = 1'b0;
        tick(1);
        chk("no_timeout_idle", outs(), 8'h00);
`endif

        tick(2);
        chk("no_stray_tx", obs_msg_q.size(), 0);
        chk("no_unmatched_exp", exp_q.size(), 0);
        chk("msg_stable", n_unstable, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mbtrain_rx_cal_rx.md
# mbtrain_rx_cal_rx

Responder-side partner of the MBTRAIN RX-clock calibration substep initiator. It consumes the sideband requests the initiator emits and answers each one:
- start request `4'b0001` → start response `4'b0010`;
- end request `4'b0011` → end response `4'b0100`.

Between the two it drives the local receiver calibration engine. The block sits beside the initiator under the MBTRAIN sequencer, and its outputs feed the shared sideband TX mux.

## Interface
- `CAL_MAX_CYCLES`, default 64: upper bound on cycles waited for `i_cal_done` before the start response is forced.
- `TIMEOUT_CYCLES`, default 4096: substep timeout measured from leaving IDLE. Only used with `RX_CAL_TIMEOUT_EN`.
- `clk` input 1: single clock. All logic on rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `i_en` input 1: substep enable from MBTRAIN sequencer. Level.
- `i_decoded_sideband_message` input 4: decoded received message code.
- `i_sideband_valid` input 1: qualifies `i_decoded_sideband_message` for one cycle.
- `i_busy_negedge_detected` input 1: sideband TX finished a transfer.
- `i_valid_rx` input 1: competing (initiator) valid on the shared TX mux.
- `i_cal_done` input 1: receiver calibration engine finished.
- `o_sideband_message` output 4: message code to transmit.
- `o_valid_tx` output 1: message pending on the TX mux.
- `o_cal_en` output 1: enables the receiver calibration engine.
- `o_test_ack` output 1: substep completed.
- `o_timeout` output 1: substep timed out.

## Operation
- **States:** IDLE, WAIT_START_REQ, CAL, SEND_START_RESP, WAIT_END_REQ, SEND_END_RESP, DONE, TIMEOUT.
- **IDLE:** all outputs 0. `i_en`=1 → WAIT_START_REQ.
- **WAIT_START_REQ:** `i_sideband_valid` && message == `4'b0001` → CAL. `o_cal_en` is set to 1 on the same edge. All other messages are ignored.
- **CAL:** a counter starts at 0.
  - Leave on `i_cal_done`=1 or when the counter reaches `CAL_MAX_CYCLES`-1, whichever comes first.
  - On exit: → SEND_START_RESP, load `o_sideband_message`=`4'b0010`, set `o_valid_tx`=1.
- **SEND_START_RESP:** wait for the valid clear, then → WAIT_END_REQ. `o_cal_en` stays 1.
- **WAIT_END_REQ:** a valid `4'b0011` → SEND_END_RESP.
  - On that edge: `o_cal_en`=0, `o_sideband_message`=`4'b0100`, `o_valid_tx`=1.
- **Early end request:** a valid `4'b0011` received in CAL or SEND_START_RESP sets a pending flag. WAIT_END_REQ then leaves on its first cycle. The flag clears on that exit.
- **SEND_END_RESP:** wait for the valid clear, then → DONE. On that edge `o_test_ack`=1 and `o_sideband_message`=0.
- **DONE:** hold `o_test_ack`=1. `i_en`=0 → IDLE.
- **Valid clear rule:** `o_valid_tx` → 0 on the cycle after `i_busy_negedge_detected`=1 && `i_valid_rx`=0. If `i_valid_rx`=1 at the busy negedge, the message stays pending.
- **Abort:** `i_en`=0 in any state other than IDLE → IDLE on the next edge. All outputs and internal flags and counters clear on that edge.

## Timing
- **Reset values:** `rst` synchronous. State IDLE. `o_sideband_message`=0, `o_valid_tx`=0, `o_cal_en`=0, `o_test_ack`=0, `o_timeout`=0. Counters and pending flag 0.
- **Reset priority:** `rst` overrides all else, including mid-operation.
- **Message latency:** a valid start request at edge N gives `o_cal_en`=1 after edge N.
- **Minimum start-response latency:** with `i_cal_done` already high, `o_valid_tx`=1 two edges after the request cycle.
- **Output timing:** outputs are registered; there is no combinational path from inputs to outputs.
- **CAL duration:** at most `CAL_MAX_CYCLES` cycles.
- **Counter widths:** `$clog2` of each parameter, minimum 1. Counters saturate and never wrap.
- **Message/valid alignment:** `o_sideband_message` is stable while `o_valid_tx`=1.

## Configuration
- **`RX_CAL_TIMEOUT_EN` defined:**
  - A counter runs in every state except IDLE, DONE and TIMEOUT.
  - At `TIMEOUT_CYCLES` it forces TIMEOUT. On that edge: `o_timeout`=1, `o_cal_en`=0, `o_valid_tx`=0.
  - TIMEOUT holds until `i_en`=0, then → IDLE.
- **Not defined:** no timeout counter, the TIMEOUT state is unreachable, and `o_timeout` is tied to 0.

## Test plan
- **Nominal handshake:** `i_en`=1; start request `0001`; `i_cal_done` after 5 cycles; busy negedge with `i_valid_rx`=0; end request `0011`; busy negedge.
  - Expect: `o_cal_en` high for the calibration window, `0010` then `0100` sent, `o_test_ack`=1.
  - Then `i_en`=0 → `o_test_ack`=0 next cycle.
- **Calibration cap:** `i_cal_done` never asserted, `CAL_MAX_CYCLES`=64 → `0010` valid exactly 64 cycles after CAL entry.
- **Early end request:** `0011` received while still in CAL → `0100` sent immediately after the `0010` valid clears; no request lost.
- **Mux contention:** busy negedge while `i_valid_rx`=1 → `o_valid_tx` stays 1. A later negedge with `i_valid_rx`=0 clears it.
- **Abort and reset:**
  - `i_en`=0 while in CAL → all outputs 0 next cycle.
  - `rst`=1 while in SEND_END_RESP → IDLE and all outputs 0 next edge.
- **Timeout (`RX_CAL_TIMEOUT_EN`, `TIMEOUT_CYCLES`=100):** no start request → `o_timeout`=1 100 cycles after leaving IDLE, cleared after `i_en`=0.
